// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and default sizes for the write-back arbiter
// Contents: requester_e (which producer owns the write port), wb_req_t (one
// write-back payload at default sizes), default WIDTH/VECTOR_WIDTH/ADDRESSWIDTH.
package wb_pkg;

    localparam int WB_WIDTH        = 24;
    localparam int WB_VECTOR_WIDTH = 8;
    localparam int WB_ADDRESSWIDTH = 4;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } requester_e;

    typedef struct packed {
        logic [WB_ADDRESSWIDTH-1:0]                 addr;
        logic [WB_WIDTH-1:0]                        data;
        logic [WB_VECTOR_WIDTH-1:0][WB_WIDTH-1:0]   data_v;
        logic                                       isvector;
        logic                                       vect_esc;
        logic [2:0]                                 index;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-destination bits and decode hazard lookup
// Ports: clock, reset (async active-low); issue_valid/issue_dest mark a register
// pending; clear_valid/clear_addr retire it; rd_addr1/rd_addr2 plus issue_dest
// are looked up to form hazard.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int ADDRESSWIDTH = WB_ADDRESSWIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    issue_valid,
    input  logic [ADDRESSWIDTH-1:0] issue_dest,
    input  logic                    clear_valid,
    input  logic [ADDRESSWIDTH-1:0] clear_addr,
    input  logic [ADDRESSWIDTH-1:0] rd_addr1,
    input  logic [ADDRESSWIDTH-1:0] rd_addr2,
    output logic                    hazard
);

    localparam int DEPTH = 1 << ADDRESSWIDTH;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_next;

    // The set is applied after the clear so a re-issue of the register being
    // retired this cycle stays pending.
    always_comb begin
        pending_next = pending;
        if (clear_valid) begin
            pending_next[clear_addr] = 1'b0;
        end
        if (issue_valid) begin
            pending_next[issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Registered bits only: a write retiring this cycle still stalls decode.
    assign hazard = pending[rd_addr1] | pending[rd_addr2] | pending[issue_dest];

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin ALU/MEM write-back arbiter with scoreboard
// Ports: clock, reset (async active-low); alu_*/mem_* requests with valid/ready
// handshake; registered register-file write port writeEnable, writeAddress,
// dataToSave, dataToSave_v, isvector_A, vect_esc_A, index_A; issue_valid,
// issue_dest, rd_addr1, rd_addr2 and hazard for decode stalls.
// Build option: WB_SCOREBOARD_EN builds the scoreboard; otherwise hazard is 0.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int WIDTH        = WB_WIDTH,
    parameter int VECTOR_WIDTH = WB_VECTOR_WIDTH,
    parameter int ADDRESSWIDTH = WB_ADDRESSWIDTH
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                alu_valid,
    output logic                                alu_ready,
    input  logic [ADDRESSWIDTH-1:0]             alu_addr,
    input  logic [WIDTH-1:0]                    alu_data,
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  alu_data_v,
    input  logic                                alu_isvector,
    input  logic                                alu_vect_esc,
    input  logic [2:0]                          alu_index,
    input  logic                                mem_valid,
    output logic                                mem_ready,
    input  logic [ADDRESSWIDTH-1:0]             mem_addr,
    input  logic [WIDTH-1:0]                    mem_data,
    input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  mem_data_v,
    input  logic                                mem_isvector,
    input  logic                                mem_vect_esc,
    input  logic [2:0]                          mem_index,
    output logic                                writeEnable,
    output logic [ADDRESSWIDTH-1:0]             writeAddress,
    output logic [WIDTH-1:0]                    dataToSave,
    output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  dataToSave_v,
    output logic                                isvector_A,
    output logic                                vect_esc_A,
    output logic [2:0]                          index_A,
    input  logic                                issue_valid,
    input  logic [ADDRESSWIDTH-1:0]             issue_dest,
    input  logic [ADDRESSWIDTH-1:0]             rd_addr1,
    input  logic [ADDRESSWIDTH-1:0]             rd_addr2,
    output logic                                hazard
);

    requester_e last;
    logic       transfer;

    // A lone requester always wins; on a tie the one not granted last wins.
    assign alu_ready = alu_valid & (~mem_valid | (last == REQ_MEM));
    assign mem_ready = mem_valid & (~alu_valid | (last == REQ_ALU));
    assign transfer  = alu_ready | mem_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last         <= REQ_MEM;
            writeEnable  <= 1'b0;
            writeAddress <= '0;
            dataToSave   <= '0;
            dataToSave_v <= '0;
            isvector_A   <= 1'b0;
            vect_esc_A   <= 1'b0;
            index_A      <= '0;
        end else begin
            writeEnable <= transfer;
            // Payload only moves on a transfer so idle cycles hold the last write.
            if (transfer) begin
                last         <= alu_ready ? REQ_ALU : REQ_MEM;
                writeAddress <= alu_ready ? alu_addr     : mem_addr;
                dataToSave   <= alu_ready ? alu_data     : mem_data;
                dataToSave_v <= alu_ready ? alu_data_v   : mem_data_v;
                isvector_A   <= alu_ready ? alu_isvector : mem_isvector;
                vect_esc_A   <= alu_ready ? alu_vect_esc : mem_vect_esc;
                index_A      <= alu_ready ? alu_index    : mem_index;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    wb_scoreboard #(
        .ADDRESSWIDTH (ADDRESSWIDTH)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .clear_valid (writeEnable),
        .clear_addr  (writeAddress),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .hazard      (hazard)
    );
`else
    logic unused_scoreboard_inputs;
    assign unused_scoreboard_inputs = ^{issue_valid, issue_dest, rd_addr1, rd_addr2};
    assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;
    import wb_pkg::*;

    localparam int W = WB_WIDTH;
    localparam int V = WB_VECTOR_WIDTH;
    localparam int A = WB_ADDRESSWIDTH;
`ifdef WB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    typedef struct packed {
        logic    we;
        wb_req_t req;
    } out_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            alu_valid = 1'b0;
    logic            mem_valid = 1'b0;
    wb_req_t         alu_req = '0;
    wb_req_t         mem_req = '0;
    logic            issue_valid = 1'b0;
    logic [A-1:0]    issue_dest = '0;
    logic [A-1:0]    rd_addr1 = '0;
    logic [A-1:0]    rd_addr2 = '0;
    logic            alu_ready, mem_ready, writeEnable, isvector_A, vect_esc_A, hazard;
    logic [A-1:0]    writeAddress;
    logic [W-1:0]    dataToSave;
    logic [V-1:0][W-1:0] dataToSave_v;
    logic [2:0]      index_A;

    int   checks = 0;
    int   errors = 0;
    bit   model_on = 1'b0;
    out_t cur;
    out_t exp_q[$];
    bit   m_last;
    bit [(1<<A)-1:0] pend;
    bit   alu_xfer, mem_xfer;

    wb_port_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_req.addr),
        .alu_data     (alu_req.data),
        .alu_data_v   (alu_req.data_v),
        .alu_isvector (alu_req.isvector),
        .alu_vect_esc (alu_req.vect_esc),
        .alu_index    (alu_req.index),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_req.addr),
        .mem_data     (mem_req.data),
        .mem_data_v   (mem_req.data_v),
        .mem_isvector (mem_req.isvector),
        .mem_vect_esc (mem_req.vect_esc),
        .mem_index    (mem_req.index),
        .writeEnable  (writeEnable),
        .writeAddress (writeAddress),
        .dataToSave   (dataToSave),
        .dataToSave_v (dataToSave_v),
        .isvector_A   (isvector_A),
        .vect_esc_A   (vect_esc_A),
        .index_A      (index_A),
        .issue_valid  (issue_valid),
        .issue_dest   (issue_dest),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .hazard       (hazard)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_init();
        cur = '0;
        exp_q.delete();
        exp_q.push_back(cur);
        m_last   = 1'b1;
        pend     = '0;
        alu_xfer = 1'b0;
        mem_xfer = 1'b0;
    endtask

    function automatic wb_req_t mk_req(input int addr, input int data, input bit isv);
        wb_req_t r;
        r = '0;
        r.addr = A'(addr);
        r.data = W'(data);
        r.isvector = isv;
        return r;
    endfunction

    function automatic wb_req_t rand_req();
        wb_req_t r;
        r.addr     = A'($urandom_range(0, (1<<A)-1));
        r.data     = W'($urandom);
        for (int i = 0; i < V; i++) r.data_v[i] = W'($urandom);
        r.isvector = 1'($urandom);
        r.vect_esc = 1'($urandom);
        r.index    = 3'($urandom);
        return r;
    endfunction

    // Reference model: grant rule, pending set/clear and expected write port.
    initial begin
        int   g;
        out_t nxt;
        forever begin
            @(negedge clock);
            #1;
            if (model_on) begin
                chk("hazard", hazard, SB_EN && (pend[rd_addr1] || pend[rd_addr2] || pend[issue_dest]));
                if (alu_valid && mem_valid) g = m_last ? 0 : 1;
                else if (alu_valid)         g = 0;
                else if (mem_valid)         g = 1;
                else                        g = -1;
                chk("alu_ready", alu_ready, g == 0);
                chk("mem_ready", mem_ready, g == 1);
                if (cur.we) pend[cur.req.addr] = 1'b0;
                if (issue_valid) pend[issue_dest] = 1'b1;
                nxt = cur;
                nxt.we = (g >= 0);
                if (g == 0) nxt.req = alu_req;
                if (g == 1) nxt.req = mem_req;
                if (g >= 0) m_last = (g == 1);
                alu_xfer = (g == 0);
                mem_xfer = (g == 1);
                exp_q.push_back(nxt);
                cur = nxt;
            end
        end
    end

    // Monitor: registered write port against the queued expectation.
    initial begin
        out_t e, a;
        forever begin
            @(negedge clock);
            if (model_on) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_out_queue actual=empty required=entry");
                end else begin
                    e = exp_q.pop_front();
                    a = {writeEnable, writeAddress, dataToSave, dataToSave_v, isvector_A, vect_esc_A, index_A};
                    if (a !== e) begin
                        errors++;
                        $display("FAIL wb_out actual we=%0d addr=%0d data=%h vec=%h isv=%0d esc=%0d idx=%0d required we=%0d addr=%0d data=%h vec=%h isv=%0d esc=%0d idx=%0d",
                                 a.we, a.req.addr, a.req.data, a.req.data_v, a.req.isvector, a.req.vect_esc, a.req.index,
                                 e.we, e.req.addr, e.req.data, e.req.data_v, e.req.isvector, e.req.vect_esc, e.req.index);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clock);
        #2;
        model_init();
        model_on = 1'b1;
        reset = 1'b1;
    endtask

    task automatic send(input bit to_mem, input wb_req_t r);
        int n = 0;
        if (to_mem) begin mem_req = r; mem_valid = 1'b1; end
        else        begin alu_req = r; alu_valid = 1'b1; end
        do begin
            step();
            n++;
        end while (!(to_mem ? mem_xfer : alu_xfer) && n < 10);
        chk("send_granted", n < 10, 1);
        if (to_mem) mem_valid = 1'b0;
        else        alu_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((alu_valid || mem_valid) && n < 10) begin
            if (alu_xfer) alu_valid = 1'b0;
            if (mem_xfer) mem_valid = 1'b0;
            if (alu_valid || mem_valid) begin
                step();
                n++;
            end
        end
        chk("drain_done", alu_valid | mem_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        wb_req_t r;

        // Reset held with both requesters valid.
        alu_req = mk_req(3, 'h00000A, 1'b0);
        mem_req = mk_req(5, 'h000014, 1'b0);
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_we", writeEnable, 0);
        chk("rst_addr", writeAddress, 0);
        chk("rst_data", dataToSave, 0);
        chk("rst_data_v", dataToSave_v != '0, 0);
        chk("rst_flags", {isvector_A, vect_esc_A, index_A}, 0);
        chk("rst_hazard", hazard, 0);
        release_reset();

        // Continuous contention: ALU first, then alternate 3,5,3,5.
        repeat (6) step();
        drain();
        step();

        // MEM-only vector write, elements 1..8.
        r = mk_req(2, 0, 1'b1);
        for (int i = 0; i < V; i++) r.data_v[i] = W'(i + 1);
        send(1'b1, r);
        step();

        // Hazard on 7 until the write to 7 has retired.
        issue_dest = 4'd7;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        rd_addr1 = 4'd7;
        repeat (2) step();
        send(1'b0, mk_req(7, 'h000077, 1'b0));
        repeat (3) step();
        rd_addr1 = 4'd0;

        // Re-issue of 4 in the cycle its write commits keeps it pending.
        send(1'b0, mk_req(4, 'h000044, 1'b0));
        issue_dest = 4'd4;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        issue_dest = 4'd0;
        rd_addr2 = 4'd4;
        repeat (2) step();
        send(1'b0, mk_req(4, 'h000045, 1'b0));
        repeat (2) step();
        rd_addr2 = 4'd0;

        // Asynchronous reset while 6 is pending and a write is on the port.
        issue_dest = 4'd6;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        issue_dest = 4'd0;
        rd_addr1 = 4'd6;
        send(1'b0, mk_req(3, 'h000033, 1'b0));
        #2;
        model_on = 1'b0;
        chk("pre_rst_we", writeEnable, 1);
        chk("pre_rst_hazard", hazard, SB_EN);
        reset = 1'b0;
        #1;
        chk("async_rst_we", writeEnable, 0);
        chk("async_rst_addr", writeAddress, 0);
        chk("async_rst_hazard", hazard, 0);
        release_reset();
        repeat (3) step();
        rd_addr1 = 4'd0;

        // Randomised traffic honouring the hold-until-ready contract.
        for (int c = 0; c < 400; c++) begin
            if (!alu_valid || alu_xfer) begin
                alu_valid = ($urandom % 3) != 0;
                alu_req = rand_req();
            end
            if (!mem_valid || mem_xfer) begin
                mem_valid = ($urandom % 3) != 0;
                mem_req = rand_req();
            end
            issue_valid = ($urandom % 4) == 0;
            issue_dest  = A'($urandom);
            rd_addr1    = A'($urandom);
            rd_addr2    = A'($urandom);
            step();
        end
        issue_valid = 1'b0;
        drain();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
